// File: rtl/rv_boot_pkg.sv
// rv_boot_pkg: shared loader state encoding, word-count width and byte order.
package rv_boot_pkg;

    typedef enum logic [2:0] {HOLD, LEN0, LEN1, DATA, FIN, RUN} state_t;

    localparam int CNT_W = 16;

    // Each word's first byte on the stream lands in bits [7:0].
    localparam bit BYTE_LE = 1'b1;

endpackage

// File: rtl/rv_word_packer.sv
// rv_word_packer: packs accepted stream bytes into 32-bit words.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : restart packing at a word boundary (new load)
//   en         : a data byte is accepted this cycle
//   data       : the accepted byte
//   word_valid : high in the cycle the 4th byte of a word is accepted
//   word       : the completed word, valid together with word_valid
module rv_word_packer
    import rv_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    logic [23:0] sr;

    // Only three bytes are stored; the fourth completes the word combinationally.
    assign word_valid = en && cnt == 2'd3;
    assign word       = BYTE_LE ? {data, sr} : {sr, data};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
            sr  <= '0;
        end else if (en) begin
            cnt <= cnt + 2'd1;
            sr  <= BYTE_LE ? {data, sr[23:8]} : {sr[15:0], data};
        end
    end

endmodule

// File: rtl/rv_imem_loader.sv
// rv_imem_loader: boot loader writing a length-prefixed byte image into the instruction RAM.
//   clk, rst      : clock, synchronous active-high reset
//   start_i       : load request, honoured in HOLD or RUN
//   byte_valid_i  : stream byte valid;  byte_data_i : stream byte
//   byte_ready_o  : loader accepts a byte this cycle
//   wena_o, addra_o, dina_o : RAM port-A write enable, word address, data
//   core_hold_o   : core held in reset while 1
//   busy_o        : load in progress;  done_o : one-cycle completion pulse
//   ovf_o         : sticky, image longer than DEPTH words
//   words_o       : word count of the current or last image
module rv_imem_loader
    import rv_boot_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              wena_o,
    output logic [ADDR_W-1:0] addra_o,
    output logic [31:0]       dina_o,
    output logic              core_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              ovf_o,
    output logic [CNT_W-1:0]  words_o
);

    state_t           state, state_n;
    logic             accept, go, word_valid, last;
    logic [31:0]      word;
    logic [7:0]       n_lo;
    logic [CNT_W-1:0] widx;

    assign accept = byte_valid_i && byte_ready_o;
    assign go     = start_i && (state == HOLD || state == RUN);
    // words_o already holds N once DATA is entered, and N >= 1 there.
    assign last   = widx == words_o - CNT_W'(1);

    rv_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (go),
        .en         (accept && state == DATA),
        .data       (byte_data_i),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_n = state;
        case (state)
            HOLD, RUN: state_n = go ? LEN0 : state;
            LEN0:      state_n = accept ? LEN1 : LEN0;
            LEN1:      state_n = !accept ? LEN1 : ({byte_data_i, n_lo} == '0) ? FIN : DATA;
            DATA:      state_n = (word_valid && last) ? FIN : DATA;
            FIN:       state_n = RUN;
            default:   state_n = HOLD;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HOLD;
            byte_ready_o <= 1'b0;
            busy_o       <= 1'b0;
            core_hold_o  <= 1'b1;
            done_o       <= 1'b0;
            wena_o       <= 1'b0;
            addra_o      <= '0;
            dina_o       <= '0;
            ovf_o        <= 1'b0;
            words_o      <= '0;
            n_lo         <= '0;
            widx         <= '0;
        end else begin
            state        <= state_n;
            byte_ready_o <= state_n inside {LEN0, LEN1, DATA};
            busy_o       <= state_n inside {LEN0, LEN1, DATA, FIN};
            core_hold_o  <= state_n != RUN;
            done_o       <= state == FIN;
            wena_o       <= word_valid && widx < CNT_W'(DEPTH);
            if (word_valid) begin
                addra_o <= widx[ADDR_W-1:0];
                dina_o  <= word;
                widx    <= widx + CNT_W'(1);
            end
            // Words past the RAM are still consumed, only flagged.
            if (word_valid && widx >= CNT_W'(DEPTH))
                ovf_o <= 1'b1;
            if (go) begin
                ovf_o <= 1'b0;
                widx  <= '0;
            end
            if (state == LEN0 && accept)
                n_lo <= byte_data_i;
            if (state == LEN1 && accept)
                words_o <= {byte_data_i, n_lo};
        end
    end

endmodule

// File: tb/tb_rv_imem_loader.sv
// tb_rv_imem_loader: randomized stream bench with a byte-counting reference model.
module tb_rv_imem_loader;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam int CLK    = 10;

    typedef logic [7:0] bq_t[$];

    logic              clk = 1'b0;
    logic              rst, start_i, byte_valid_i;
    logic [7:0]        byte_data_i;
    logic              byte_ready_o, wena_o, core_hold_o, busy_o, done_o, ovf_o;
    logic [ADDR_W-1:0] addra_o;
    logic [31:0]       dina_o;
    logic [15:0]       words_o;

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;
    logic [ADDR_W-1:0] waddr[$];
    logic [31:0]       wdata[$];

    rv_imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .wena_o       (wena_o),
        .addra_o      (addra_o),
        .dina_o       (dina_o),
        .core_hold_o  (core_hold_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .ovf_o        (ovf_o),
        .words_o      (words_o)
    );

    always #(CLK/2) clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks the load purely by counting accepted stream bytes.
    logic              e_ready = 0, e_wena = 0, e_hold = 1, e_busy = 0, e_done = 0, e_ovf = 0, e_fin = 0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [31:0]       e_dina = '0;
    logic [15:0]       e_words = '0;
    logic [7:0]        m_b[4];
    bit                m_active = 0;
    int                m_cnt = 0, m_n = 0, m_k;

    always @(posedge clk) begin
        if (rst) begin
            e_ready = 0; e_wena = 0; e_hold = 1; e_busy = 0; e_done = 0; e_ovf = 0; e_fin = 0;
            e_addr = '0; e_dina = '0; e_words = '0; m_active = 0; m_cnt = 0;
        end else begin
            e_wena = 0;
            e_done = 0;
            if (e_fin) begin
                e_fin = 0; e_busy = 0; e_hold = 0; e_done = 1;
            end else if (!m_active && start_i) begin
                m_active = 1; m_cnt = 0; e_ready = 1; e_busy = 1; e_hold = 1; e_ovf = 0;
            end else if (e_ready && byte_valid_i) begin
                if (m_cnt == 0) m_n = int'(byte_data_i);
                else if (m_cnt == 1) begin
                    m_n = m_n + (int'(byte_data_i) << 8);
                    e_words = 16'(m_n);
                end else m_b[(m_cnt - 2) % 4] = byte_data_i;
                m_cnt++;
                if (m_cnt > 2 && (m_cnt - 2) % 4 == 0) begin
                    m_k = (m_cnt - 2) / 4 - 1;
                    if (m_k < DEPTH) begin
                        e_wena = 1;
                        e_addr = ADDR_W'(m_k);
                        e_dina = {m_b[3], m_b[2], m_b[1], m_b[0]};
                    end else e_ovf = 1;
                end
                if (m_cnt >= 2 && m_cnt == 2 + 4 * m_n) begin
                    e_ready = 0; e_fin = 1; m_active = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("ready", byte_ready_o, e_ready);
        chk("wena", wena_o, e_wena);
        chk("hold", core_hold_o, e_hold);
        chk("busy", busy_o, e_busy);
        chk("done", done_o, e_done);
        chk("ovf", ovf_o, e_ovf);
        chk("words", words_o, e_words);
        if (e_wena) begin
            chk("addra", addra_o, e_addr);
            chk("dina", dina_o, e_dina);
        end
        if (wena_o === 1'b1) begin
            waddr.push_back(addra_o);
            wdata.push_back(dina_o);
        end
        if (done_o === 1'b1) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1;
        tick();
        start_i = 0;
    endtask

    task automatic clear_log();
        waddr.delete();
        wdata.delete();
        n_done = 0;
    endtask

    function automatic bq_t mk(input int n);
        bq_t q;
        q.push_back(8'(n));
        q.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Streams q; rnd randomizes byte_valid_i; start_i pulses once at byte index start_at.
    task automatic send(input bq_t q, input bit rnd, input int start_at, output time last_t);
        int  i = 0, guard = 0;
        bit  acc, st = 0;
        last_t = 0;
        while (i < q.size() && guard < 10000) begin
            byte_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            byte_data_i  = q[i];
            start_i      = (i == start_at && !st);
            if (start_i) st = 1;
            acc = byte_valid_i && byte_ready_o;
            @(posedge clk);
            if (acc) begin
                i++;
                last_t = $time;
            end
            #1;
            start_i = 0;
            guard++;
        end
        byte_valid_i = 0;
        if (i < q.size()) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: sent %0d of %0d bytes", i, q.size());
        end
    endtask

    task automatic wait_done(input string nm, output time t);
        bit seen = 0;
        t = 0;
        for (int g = 0; g < 50 && !seen; g++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                seen = 1;
                t = $time;
            end
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: done_o never pulsed", nm);
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t img, part;
        time lt, dt;
        rst = 1; start_i = 0; byte_valid_i = 0; byte_data_i = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold", core_hold_o, 1);
        chk("rst_ready", byte_ready_o, 0);
        chk("rst_words", words_o, 0);
        rst = 0;
        tick();

        // Two-word image at full rate.
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        pulse_start();
        clear_log();
        send(img, 0, -1, lt);
        wait_done("t1_done", dt);
        chk("t1_latency", 32'(dt - lt), CLK + CLK / 2);
        chk("t1_nwrites", waddr.size(), 2);
        if (waddr.size() >= 2) begin
            chk("t1_a0", waddr[0], 0);
            chk("t1_d0", wdata[0], 32'h0000_0013);
            chk("t1_a1", waddr[1], 1);
            chk("t1_d1", wdata[1], 32'h0010_0093);
        end
        chk("t1_words", words_o, 2);
        chk("t1_hold", core_hold_o, 0);

        // Same image with gaps, reloaded from RUN.
        pulse_start();
        chk("t2_hold", core_hold_o, 1);
        clear_log();
        send(img, 1, -1, lt);
        wait_done("t2_done", dt);
        chk("t2_nwrites", waddr.size(), 2);
        if (waddr.size() >= 2) begin
            chk("t2_d0", wdata[0], 32'h0000_0013);
            chk("t2_d1", wdata[1], 32'h0010_0093);
        end

        // Empty image.
        pulse_start();
        clear_log();
        send('{8'h00, 8'h00}, 0, -1, lt);
        wait_done("t3_done", dt);
        chk("t3_latency", 32'(dt - lt), CLK + CLK / 2);
        repeat (5) tick();
        chk("t3_ndone", n_done, 1);
        chk("t3_nwrites", waddr.size(), 0);

        // One word more than the RAM holds.
        pulse_start();
        clear_log();
        send(mk(257), 1, -1, lt);
        wait_done("t4_done", dt);
        chk("t4_nwrites", waddr.size(), 256);
        if (waddr.size() == 256) chk("t4_last_addr", waddr[255], 255);
        chk("t4_ovf", ovf_o, 1);
        repeat (4) tick();
        chk("t4_ovf_sticky", ovf_o, 1);

        // Reload clears overflow; a start inside DATA is ignored.
        pulse_start();
        chk("t5_ovf_clr", ovf_o, 0);
        chk("t5_hold", core_hold_o, 1);
        clear_log();
        send(mk(3), 1, 8, lt);
        wait_done("t5_done", dt);
        chk("t5_nwrites", waddr.size(), 3);
        chk("t5_words", words_o, 3);

        // Reset in the middle of DATA, then a fresh load.
        pulse_start();
        img = mk(4);
        part = img[0:8];
        send(part, 0, -1, lt);
        rst = 1;
        tick();
        chk("t6_ready", byte_ready_o, 0);
        chk("t6_wena", wena_o, 0);
        chk("t6_addra", addra_o, 0);
        chk("t6_dina", dina_o, 0);
        chk("t6_hold", core_hold_o, 1);
        chk("t6_busy", busy_o, 0);
        chk("t6_done", done_o, 0);
        chk("t6_ovf", ovf_o, 0);
        chk("t6_words", words_o, 0);
        rst = 0;
        tick();
        pulse_start();
        clear_log();
        send(mk(2), 1, -1, lt);
        wait_done("t6_reload_done", dt);
        chk("t6_nwrites", waddr.size(), 2);
        chk("t6_hold_run", core_hold_o, 0);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
